adder_subtractor_unit: RTL and testbench
========================================

Name:
adder_subtractor_unit

Overview:
- Parameterised N-bit two's-complement adder/subtractor with a registered result.
- Mode input ci selects add (0) or subtract (1). In subtract mode, b is inverted and ci is used as the carry-in, so the block computes a + ~b + 1.
- Used as an arithmetic leaf block inside datapaths; operands are sampled and the result is registered on each clock edge.

Parameters:
- N, default 5: operand and result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  N  operand A (minuend in subtract mode).
- b  input  N  operand B (subtrahend in subtract mode).
- ci  input  1  mode/carry-in: 0 = add, 1 = subtract.
- sum  output  N  registered result, low N bits.
- co  output  1  registered carry-out of the MSB stage.
- ovf  output  1  registered signed-overflow flag.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Combinational core:
  - Ripple-carry chain of N full-adder stages built with a generate loop.
  - Stage i inputs: a[i], b[i] XOR ci, and carry c[i]; c[0] = ci.
  - Stage i outputs: s[i] and c[i+1].
- Result definitions:
  - sum_next = (a + (b XOR {N{ci}}) + ci) mod 2^N.
  - co_next = c[N].
  - ovf_next = c[N] XOR c[N-1], i.e. the signed result is not representable in N bits.
- Add mode (ci=0):
  - sum = (a+b) mod 2^N.
  - co = 1 when unsigned a+b >= 2^N.
- Subtract mode (ci=1):
  - sum = (a-b) mod 2^N.
  - co = 1 means no borrow (unsigned a >= b); co = 0 means borrow.
  - a == b gives sum=0, co=1.
- Registration:
  - On every rising clk with rst low, sum/co/ovf load sum_next/co_next/ovf_next.
  - Latency is exactly 1 cycle; throughput is one operation per cycle.
  - There is no handshake or enable; the registers load every cycle.
- Reset:
  - rst high forces sum=0, co=0, ovf=0 immediately, independent of clk.
  - Outputs hold 0 while rst is high.
  - The first valid result appears at the first rising edge after rst deasserts.
  - Asserting rst mid-stream discards the in-flight result; no partial state survives.
- Wrap-around:
  - Results wrap modulo 2^N.
  - There is no saturation; co and ovf are the only indicators of wrap.
- Inputs containing X/Z give undefined outputs; no special handling is required.
- Every stage is full-adder logic. There is no behavioural '+' on the full N-bit operands, so the carry chain (c[N], c[N-1]) is explicit for ovf.

Test Plan (N=5):
- Reset: assert rst asynchronously between clock edges -> sum=0, co=0, ovf=0 before the next edge; outputs stay 0 until rst deasserts.
- Add: a=5, b=3, ci=0 -> one cycle later sum=8, co=0, ovf=0.
- Add boundaries:
  - a=31, b=1, ci=0 -> sum=0, co=1, ovf=0.
  - a=15, b=1, ci=0 -> sum=16, co=0, ovf=1.
- Subtract:
  - a=5, b=3, ci=1 -> sum=2, co=1, ovf=0.
  - a=3, b=5, ci=1 -> sum=30, co=0, ovf=0.
  - a=b=9, ci=1 -> sum=0, co=1.
- Subtract overflow: a=16 (-16), b=1, ci=1 -> sum=15, co=1, ovf=1.
- Random/back-to-back: apply new random a/b/ci every cycle for ≥1000 cycles -> each output equals the reference model of the previous cycle's inputs. Include a rst pulse mid-stream and check the outputs are 0, then resume.

Source files
------------

// File: rtl/adder_subtractor_unit.sv
// N-bit two's-complement adder/subtractor: explicit ripple-carry chain of full adders,
// with sum, carry-out and signed-overflow registered each clock.
module adder_subtractor_unit #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  logic [N-1:0] b_eff;
  logic [N-1:0] sum_next;
  logic [N:0]   carry;
  logic         co_next;
  logic         ovf_next;

  // ci doubles as the mode bit and the carry-in, so subtract becomes a + ~b + 1
  assign carry[0] = ci;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    assign b_eff[gi]    = b[gi] ^ ci;
    assign sum_next[gi] = a[gi] ^ b_eff[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
  end

  assign co_next  = carry[N];
  // Signed overflow: the carry into the sign bit disagrees with the carry out of it
  assign ovf_next = carry[N] ^ carry[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sum <= sum_next;
      co  <= co_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_adder_subtractor_unit.sv
// Self-checking bench for adder_subtractor_unit (N=5): directed vectors with
// hand-computed results, asynchronous reset checks, and a long back-to-back random run.
module tb_adder_subtractor_unit;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] a   = '0;
  logic [N-1:0] b   = '0;
  logic         ci  = 1'b0;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;

  int tests_run = 0;
  int tests_failed = 0;

  adder_subtractor_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .sum (sum),
    .co  (co),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: integer arithmetic, overflow from the signed range.
  task automatic ref_model(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rci,
                           output logic [N-1:0] es, output logic eco, output logic eovf);
    int ua, ub, sa, sb, full, sres;
    ua = int'(ra);
    ub = int'(rb);
    sa = (ua >= 16) ? ua - 32 : ua;
    sb = (ub >= 16) ? ub - 32 : ub;
    if (rci) begin
      full = ua + (31 - ub) + 1;
      sres = sa - sb;
    end else begin
      full = ua + ub;
      sres = sa + sb;
    end
    es   = N'(full % 32);
    eco  = (full >= 32);
    eovf = (sres < -16) || (sres > 15);
  endtask

  task automatic apply_vec(input string tag, input int va, input int vb, input int vci,
                           input int es, input int eco, input int eovf);
    @(negedge clk);
    a  = N'(va);
    b  = N'(vb);
    ci = vci[0];
    @(posedge clk);
    #1;
    check_value({tag, ".sum"}, 64'(sum), 64'(es));
    check_value({tag, ".co"},  64'(co),  64'(eco));
    check_value({tag, ".ovf"}, 64'(ovf), 64'(eovf));
    $display("[TB] %s a=%0d b=%0d ci=%0d -> sum=%0d co=%0d ovf=%0d", tag, va, vb, vci, sum, co, ovf);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] ra, rb, es;
    logic         rci, eco, eovf;

    // Reset held from time 0: outputs must be zero across clock edges
    #1;
    check_value("rst_init.sum", 64'(sum), 64'd0);
    check_value("rst_init.co",  64'(co),  64'd0);
    check_value("rst_init.ovf", 64'(ovf), 64'd0);
    a = 5'd31; b = 5'd31; ci = 1'b0;
    @(posedge clk); #1;
    check_value("rst_hold.sum", 64'(sum), 64'd0);
    check_value("rst_hold.co",  64'(co),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    apply_vec("add_5_3",      5,  3, 0,  8, 0, 0);
    apply_vec("add_31_1",    31,  1, 0,  0, 1, 0);
    apply_vec("add_15_1",    15,  1, 0, 16, 0, 1);
    apply_vec("add_16_16",   16, 16, 0,  0, 1, 1);
    apply_vec("sub_5_3",      5,  3, 1,  2, 1, 0);
    apply_vec("sub_3_5",      3,  5, 1, 30, 0, 0);
    apply_vec("sub_9_9",      9,  9, 1,  0, 1, 0);
    apply_vec("sub_0_0",      0,  0, 1,  0, 1, 0);
    apply_vec("sub_16_1",    16,  1, 1, 15, 1, 1);
    apply_vec("sub_15_16",   15, 16, 1, 31, 0, 1);

    // Asynchronous reset between edges, with a nonzero result currently held
    apply_vec("pre_rst",     31,  1, 0,  0, 1, 0);
    apply_vec("pre_rst2",    15,  1, 0, 16, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_value("rst_async.sum", 64'(sum), 64'd0);
    check_value("rst_async.co",  64'(co),  64'd0);
    check_value("rst_async.ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    check_value("rst_async_hold.sum", 64'(sum), 64'd0);
    check_value("rst_async_hold.ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_vec("post_rst",     5,  3, 0,  8, 0, 0);

    // Back-to-back random operations with one mid-stream reset pulse
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      ra  = N'($urandom_range(0, 31));
      rb  = N'($urandom_range(0, 31));
      rci = 1'($urandom_range(0, 1));
      a = ra; b = rb; ci = rci;
      if (i == 600) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_value("rnd_rst.sum", 64'(sum), 64'd0);
        check_value("rnd_rst.co",  64'(co),  64'd0);
        check_value("rnd_rst.ovf", 64'(ovf), 64'd0);
        $display("[TB] rnd %0d reset pulse -> sum=%0d co=%0d ovf=%0d", i, sum, co, ovf);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        ref_model(ra, rb, rci, es, eco, eovf);
        @(posedge clk); #1;
        check_value("rnd.sum", 64'(sum), 64'(es));
        check_value("rnd.co",  64'(co),  64'(eco));
        check_value("rnd.ovf", 64'(ovf), 64'(eovf));
        $display("[TB] rnd %0d a=%0d b=%0d ci=%0d -> sum=%0d co=%0d ovf=%0d", i, ra, rb, rci, sum, co, ovf);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
